// File: rtl/dbus_responder_ram.sv
`timescale 1ns/1ps
// dbus_responder_ram: data-bus slave responder backed by a word-addressed 64-bit RAM.
// Latency: accept at cycle t gives resp_data_ok at t+LATENCY (plus 0..3 extra cycles
//   from an LFSR when DBUS_RESP_RANDOM_DELAY_EN is defined); one transaction per LATENCY+1 cycles.
// Backpressure: a single transaction in flight; requests are accepted only while IDLE.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid           request valid, held by the core until resp_data_ok
//   req_addr/size       byte address and access size (size is latched, not used for data)
//   req_strobe/data     byte write enables (0 = read) and lane-aligned write data
//   resp_addr_ok        combinational accept pulse (IDLE and req_valid)
//   resp_data_ok        one-cycle response pulse, qualifies resp_data
//   resp_data           full aligned word read before any write of the same transaction
//   busy                registered, high while a transaction is in flight
module dbus_responder_ram #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [4:0]    counter;
    logic [63:0]   lat_addr;
    logic [63:0]   lat_data;
    logic [2:0]    lat_size;
    logic [7:0]    lat_strobe;
    logic [63:0]   mem [DEPTH];

    logic [4:0]    extra;
    logic [4:0]    load_cnt;
    logic [63:0]   rd_addr;
    logic [63:0]   rd_word;
    logic [AW-1:0] rd_index;
    logic [AW-1:0] wr_index;
    logic          rd_in_range;
    logic          wr_in_range;

`ifdef DBUS_RESP_RANDOM_DELAY_EN
    // Fibonacci LFSR, taps 8,6,5,4; its two LSBs at accept time stretch the latency.
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    // Counter preload; zero means the response is due in the very next cycle.
    assign load_cnt = 5'(LATENCY - 1) + extra;

    // Entering RESP straight from IDLE the latched address is not yet valid,
    // so the read port looks at the live request in IDLE.
    assign rd_addr     = (state == IDLE) ? req_addr : lat_addr;
    assign rd_index    = rd_addr[3 +: AW];
    assign rd_in_range = (rd_addr[63:3+AW] == '0);
    assign rd_word     = rd_in_range ? mem[rd_index] : 64'd0;

    assign wr_index    = lat_addr[3 +: AW];
    assign wr_in_range = (lat_addr[63:3+AW] == '0);

    assign resp_addr_ok = (state == IDLE) && req_valid && !reset;

    // Byte offset and size never alter the returned word; the core extracts bytes.
    logic unused_fields;
    assign unused_fields = ^{lat_size, rd_addr[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= 5'd0;
            resp_data_ok <= 1'b0;
            resp_data    <= 64'd0;
            busy         <= 1'b0;
        end else begin
            resp_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr   <= req_addr;
                        lat_size   <= req_size;
                        lat_strobe <= req_strobe;
                        lat_data   <= req_data;
                        counter    <= load_cnt;
                        busy       <= 1'b1;
                        if (load_cnt == 5'd0) begin
                            state        <= RESP;
                            resp_data_ok <= 1'b1;
                            resp_data    <= rd_word;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    counter <= counter - 5'd1;
                    if (counter == 5'd1) begin
                        // RAM is stable until the write at the end of RESP, so
                        // capturing here equals reading during RESP.
                        state        <= RESP;
                        resp_data_ok <= 1'b1;
                        resp_data    <= rd_word;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write lands on the edge that ends RESP; a reset in that cycle discards it.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && wr_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (lat_strobe[i]) begin
                    mem[wr_index][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dbus_responder_ram.sv
`timescale 1ns/1ps
// tb_dbus_responder_ram: scoreboard bench for dbus_responder_ram.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
// A second instance with LATENCY=1 exercises continuous req_valid.
module tb_dbus_responder_ram;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [63:0] OOR   = 64'(DEPTH * 8);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [2:0]  req_size = 3'd3;
    logic [7:0]  req_strobe = 8'd0;
    logic [63:0] req_data = 64'd0;
    logic        resp_addr_ok, resp_data_ok, busy;
    logic [63:0] resp_data;

    logic        v1 = 1'b0;
    logic        a1ok, d1ok, busy1;
    logic [63:0] rd1;

    always #5 clk = ~clk;

    dbus_responder_ram #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
        .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok),
        .resp_data(resp_data), .busy(busy)
    );

    dbus_responder_ram #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_addr(64'h40),
        .req_size(3'd3), .req_strobe(8'h00), .req_data(64'd0),
        .resp_addr_ok(a1ok), .resp_data_ok(d1ok),
        .resp_data(rd1), .busy(busy1)
    );

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory: 16 words are enough for every in-range address used.
    logic [63:0] mem [16];

    typedef struct {
        bit          care;
        logic [63:0] data;
        int          tag;
    } exp_t;
    exp_t sbq[$];
    int   tag_ctr = 0;

`ifdef DBUS_RESP_RANDOM_DELAY_EN
    logic [7:0] mlfsr;
    always @(posedge clk) begin
        if (reset) mlfsr <= 8'hA5;
        else       mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    end
    function automatic int extra_now();
        return int'(mlfsr[1:0]);
    endfunction
`else
    function automatic int extra_now();
        return 0;
    endfunction
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bail(input string what);
        nvec++;
        nfail++;
        $display("FAIL %s: timed out waiting on DUT", what);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    endtask

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        if (a >= OOR || (a >> 3) >= 64'd16) return 64'd0;
        return mem[a[6:3]];
    endfunction

    task automatic model_wr(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        if (a < OOR && (a >> 3) < 64'd16) begin
            for (int i = 0; i < 8; i++)
                if (s[i]) mem[a[6:3]][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Monitor: latency measured from the observed accept, data from the scoreboard.
    int acc_cyc = -1;
    int exp_lat = LAT;
    always @(negedge clk) begin
        exp_t e;
        if (resp_addr_ok) begin
            acc_cyc = cyc;
            exp_lat = LAT + extra_now();
        end
        if (resp_data_ok) begin
            if (sbq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_data_ok: got data_ok with no pending request (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check($sformatf("latency txn%0d", e.tag), 64'(cyc - acc_cyc), 64'(exp_lat));
                if (e.care) check($sformatf("resp_data txn%0d", e.tag), resp_data, e.data);
            end
        end
    end

    // One complete transaction; called at posedge+1 with the DUT idle.
    task automatic txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                       input bit use_const, input logic [63:0] cexp, input bit care,
                       input bit drop, output int acc);
        exp_t e;
        int   n;
        int   issue;
        bit   done;
        e.care = care;
        e.data = use_const ? cexp : model_rd(a);
        e.tag  = tag_ctr++;
        sbq.push_back(e);
        if (s != 8'd0) model_wr(a, s, d);

        issue      = cyc;
        req_valid  = 1'b1;
        req_addr   = a;
        req_strobe = s;
        req_data   = d;
        req_size   = 3'($urandom_range(0, 3));
        acc = -1;
        n   = 0;
        while (acc < 0 && n < 100) begin
            @(negedge clk);
            if (resp_addr_ok) acc = cyc;
            n++;
        end
        if (acc < 0) bail("accept");
        check($sformatf("accept_cycle txn%0d", e.tag), 64'(acc), 64'(issue));

        @(posedge clk); #1;
        check($sformatf("busy_in_flight txn%0d", e.tag), 64'(busy), 64'd1);
        // Latched copy must be used: disturb the live request.
        req_addr   = {$urandom, $urandom};
        req_data   = {$urandom, $urandom};
        req_strobe = 8'($urandom);
        if (drop) req_valid = 1'b0;

        done = 1'b0;
        n    = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (resp_data_ok) done = 1'b1;
            n++;
        end
        if (!done) bail("data_ok");
        @(posedge clk); #1;
        req_valid = 1'b0;
        check($sformatf("busy_after_resp txn%0d", e.tag), 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        bail("global watchdog");
    end

    initial begin
        int acc, rel, next_acc, exp_dok, nacc, guard, ea, ed, r, g;
        logic [63:0] a;
        logic [7:0]  s;

        for (int i = 0; i < 16; i++) mem[i] = 64'd0;

        // Reset held with a request pending: nothing may be accepted or answered.
        req_valid  = 1'b1;
        req_addr   = 64'h0;
        req_strobe = 8'hFF;
        req_data   = 64'd0;
        repeat (3) begin
            @(negedge clk);
            check("reset addr_ok", 64'(resp_addr_ok), 64'd0);
            check("reset data_ok", 64'(resp_data_ok), 64'd0);
            check("reset busy", 64'(busy), 64'd0);
            check("reset resp_data", resp_data, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rel = cyc;
        txn(64'h0, 8'hFF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, acc);
        check("first accept at reset release", 64'(acc), 64'(rel));

        // Zero the modelled words through the bus.
        for (int i = 1; i < 16; i++)
            txn(64'(i * 8), 8'hFF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, acc);

        // Full write then read back.
        txn(64'h10, 8'hFF, 64'h1122334455667788, 1'b1, 64'd0, 1'b1, 1'b0, acc);
        txn(64'h10, 8'h00, 64'd0, 1'b1, 64'h1122334455667788, 1'b1, 1'b0, acc);
        // Partial write of the low four lanes.
        txn(64'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b1, 64'h1122334455667788, 1'b1, 1'b0, acc);
        txn(64'h10, 8'h00, 64'd0, 1'b1, 64'h11223344_BBBBBBBB, 1'b1, 1'b0, acc);
        // Out of range: reads zero, writes dropped (no aliasing onto word 0).
        txn(OOR, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, acc);
        txn(OOR, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b0, acc);
        txn(64'h0, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, acc);

        // Reset during WAIT of a write: no data_ok and the RAM keeps its value.
        req_valid  = 1'b1;
        req_addr   = 64'h18;
        req_strobe = 8'hFF;
        req_data   = 64'hDEAD;
        @(negedge clk);
        check("abort accept", 64'(resp_addr_ok), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort data_ok", 64'(resp_data_ok), 64'd0);
        end
        check("abort busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        txn(64'h18, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, acc);

        // Randomized traffic against the reference memory.
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = {57'd0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            else if (r == 7) a = OOR + 64'($urandom_range(0, 1000));
            else if (r == 8) a = 64'h1_0000_0000 + 64'($urandom_range(0, 15) * 8);
            else             a = 64'hFFFF_FFFF_FFFF_FFF8;
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            txn(a, s, {$urandom, $urandom}, 1'b0, 64'd0, 1'b1, ($urandom_range(0, 7) == 0), acc);
            g = $urandom_range(0, 2);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end

        // LATENCY=1 instance with req_valid held for four transactions.
        v1 = 1'b1;
        next_acc = cyc;
        exp_dok  = -1;
        nacc  = 0;
        guard = 0;
        while (!(nacc == 4 && cyc >= exp_dok) && guard < 60) begin
            @(negedge clk);
            ea = (cyc == next_acc) ? 1 : 0;
            ed = (cyc == exp_dok) ? 1 : 0;
            check($sformatf("lat1 addr_ok c%0d", guard), 64'(a1ok), 64'(ea));
            check($sformatf("lat1 data_ok c%0d", guard), 64'(d1ok), 64'(ed));
            if (ea == 1) begin
                exp_dok  = cyc + 1 + extra_now();
                next_acc = exp_dok + 1;
                nacc++;
            end
            guard++;
        end
        if (guard >= 60) bail("lat1 schedule");
        @(posedge clk); #1;
        v1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
